// File: rtl/cache_tag_array_nway.sv
// N-way tag array: valid/dirty/tag per way with per-set round-robin replacement.
// Lookup response one cycle after acceptance; ready=0 while invalidate sweep runs.
module cache_tag_array_nway #(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 2,
  parameter int IDX_W    = 5,
  parameter int WAYS     = 2,
  localparam int TAG_W   = ADDR_W - IDX_W - OFFSET_W,
  localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int SETS    = 2**IDX_W
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              lookup_valid,
  input  logic [ADDR_W-1:0] lookup_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WAY_W-1:0]  wr_way,
  input  logic              wr_valid,
  input  logic              wr_dirty,
  input  logic              flush,
  output logic              ready,
  output logic              resp_valid,
  output logic              hit,
  output logic [WAY_W-1:0]  hit_way,
  output logic [WAY_W-1:0]  victim_way,
  output logic              victim_valid,
  output logic              victim_dirty,
  output logic [TAG_W-1:0]  victim_tag
);

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } entry_t;

  typedef enum logic {SWEEP, IDLE} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  sweep_cnt_q, sweep_cnt_d;
  entry_t            mem_q [SETS][WAYS];
  logic [WAY_W-1:0]  rr_q  [SETS];

  logic [IDX_W-1:0]  lk_idx, wr_idx;
  logic [TAG_W-1:0]  lk_tag, wr_tag;
  logic              lk_acc, wr_acc;
  logic              hit_c;
  logic [WAY_W-1:0]  hit_way_c, vic_way_c;
  entry_t            vic_c;
  logic              unused_offset;

  assign lk_idx = lookup_addr[OFFSET_W+IDX_W-1:OFFSET_W];
  assign lk_tag = lookup_addr[ADDR_W-1:OFFSET_W+IDX_W];
  assign wr_idx = wr_addr[OFFSET_W+IDX_W-1:OFFSET_W];
  assign wr_tag = wr_addr[ADDR_W-1:OFFSET_W+IDX_W];
  assign unused_offset = ^{lookup_addr[OFFSET_W-1:0], wr_addr[OFFSET_W-1:0]};

  assign ready  = (state_q == IDLE);
  // A flush in IDLE swallows any lookup/write presented alongside it.
  assign lk_acc = !iRST && ready && lookup_valid && !flush;
  assign wr_acc = !iRST && ready && wr_en && !flush;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q     <= SWEEP;
      sweep_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    case (state_q)
      SWEEP: begin
        sweep_cnt_d = sweep_cnt_q + IDX_W'(1);
        if (sweep_cnt_q == {IDX_W{1'b1}}) state_d = IDLE;
      end
      IDLE: begin
        if (flush) begin
          state_d     = SWEEP;
          sweep_cnt_d = '0;
        end
      end
      default: state_d = SWEEP;
    endcase
  end

  // Descending scans leave the lowest-numbered qualifying way selected.
  always_comb begin
    hit_c     = 1'b0;
    hit_way_c = '0;
    vic_way_c = rr_q[lk_idx];
    vic_c     = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (mem_q[lk_idx][w].valid && mem_q[lk_idx][w].tag == lk_tag) begin
        hit_c     = 1'b1;
        hit_way_c = WAY_W'(w);
      end
      if (!mem_q[lk_idx][w].valid) vic_way_c = WAY_W'(w);
    end
    for (int w = 0; w < WAYS; w++) begin
      if (WAY_W'(w) == vic_way_c) vic_c = mem_q[lk_idx][w];
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      resp_valid   <= 1'b0;
      hit          <= 1'b0;
      hit_way      <= '0;
      victim_way   <= '0;
      victim_valid <= 1'b0;
      victim_dirty <= 1'b0;
      victim_tag   <= '0;
    end else begin
      resp_valid <= lk_acc;
      if (lk_acc) begin
        hit          <= hit_c;
        hit_way      <= hit_way_c;
        victim_way   <= vic_way_c;
        victim_valid <= vic_c.valid;
        victim_dirty <= vic_c.dirty;
        victim_tag   <= vic_c.tag;
      end
    end
  end

  // Tag bits are left stale by the sweep; clearing valid is sufficient.
  always_ff @(posedge iCLK) begin
    if (!iRST && state_q == SWEEP) begin
      for (int w = 0; w < WAYS; w++) begin
        mem_q[sweep_cnt_q][w].valid <= 1'b0;
        mem_q[sweep_cnt_q][w].dirty <= 1'b0;
      end
      rr_q[sweep_cnt_q] <= '0;
    end else if (wr_acc) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == wr_way) mem_q[wr_idx][w] <= '{valid: wr_valid, dirty: wr_dirty, tag: wr_tag};
      end
      if (WAYS > 1 && wr_valid && wr_way == rr_q[wr_idx])
        rr_q[wr_idx] <= (rr_q[wr_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[wr_idx] + WAY_W'(1);
    end
  end

endmodule

// File: tb/tb_cache_tag_array_nway.sv
// Directed bench for cache_tag_array_nway at default parameters (2 ways, 32 sets).
module tb_cache_tag_array_nway;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        lookup_valid;
  logic [31:0] lookup_addr;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [0:0]  wr_way;
  logic        wr_valid;
  logic        wr_dirty;
  logic        flush;
  logic        ready;
  logic        resp_valid;
  logic        hit;
  logic [0:0]  hit_way;
  logic [0:0]  victim_way;
  logic        victim_valid;
  logic        victim_dirty;
  logic [24:0] victim_tag;

  int checks = 0;
  int errors = 0;
  int n;
  int bad;

  cache_tag_array_nway dut (
    .iCLK(iCLK), .iRST(iRST),
    .lookup_valid(lookup_valid), .lookup_addr(lookup_addr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_way(wr_way),
    .wr_valid(wr_valid), .wr_dirty(wr_dirty), .flush(flush),
    .ready(ready), .resp_valid(resp_valid), .hit(hit), .hit_way(hit_way),
    .victim_way(victim_way), .victim_valid(victim_valid),
    .victim_dirty(victim_dirty), .victim_tag(victim_tag)
  );

  always #5 iCLK = ~iCLK;

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic w, input logic v, input logic d);
    wr_en = 1'b1; wr_addr = a; wr_way = w; wr_valid = v; wr_dirty = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_lookup(input logic [31:0] a);
    lookup_valid = 1'b1; lookup_addr = a;
    step();
    lookup_valid = 1'b0;
  endtask

  // Counts cycles with ready=0 (first observation is the current one) and stray responses.
  task automatic count_sweep(output int cycles, output int stray);
    cycles = 0;
    stray  = 0;
    while (!ready && cycles < 100) begin
      cycles++;
      if (resp_valid) stray++;
      step();
    end
  endtask

  initial begin
    iRST = 1'b1; lookup_valid = 1'b0; lookup_addr = '0; wr_en = 1'b0; wr_addr = '0;
    wr_way = '0; wr_valid = 1'b0; wr_dirty = 1'b0; flush = 1'b0;
    step();
    iRST = 1'b0;

    // Reset state
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_hit", 32'(hit), 32'd0);
    chk("rst_victim_tag", 32'(victim_tag), 32'd0);
    count_sweep(n, bad);
    chk("rst_sweep_len", n, 32);
    chk("rst_sweep_resp", bad, 0);
    chk("rst_ready_after", 32'(ready), 32'd1);

    do_lookup(32'h0000_0040);
    chk("lk0_resp_valid", 32'(resp_valid), 32'd1);
    chk("lk0_hit", 32'(hit), 32'd0);
    chk("lk0_victim_way", 32'(victim_way), 32'd0);
    chk("lk0_victim_valid", 32'(victim_valid), 32'd0);
    step();
    chk("idle_resp_valid", 32'(resp_valid), 32'd0);

    // Hit on way 1, miss in the neighbouring set
    do_write(32'h1234_5678, 1'b1, 1'b1, 1'b1);
    do_lookup(32'h1234_5678);
    chk("hit_resp", 32'(resp_valid), 32'd1);
    chk("hit_hit", 32'(hit), 32'd1);
    chk("hit_way", 32'(hit_way), 32'd1);
    chk("hit_victim_way", 32'(victim_way), 32'd0);
    do_lookup(32'h1234_567C);
    chk("miss_hit", 32'(hit), 32'd0);
    chk("miss_hit_way", 32'(hit_way), 32'd0);

    // Round-robin in set 3: tags 1,2 fill, then rewrites advance the pointer
    do_write(32'h0000_008C, 1'b0, 1'b1, 1'b0);
    do_write(32'h0000_010C, 1'b1, 1'b1, 1'b0);
    do_lookup(32'h0000_018C);
    chk("rr0_hit", 32'(hit), 32'd0);
    chk("rr0_victim_way", 32'(victim_way), 32'd0);
    chk("rr0_victim_valid", 32'(victim_valid), 32'd1);
    chk("rr0_victim_tag", 32'(victim_tag), 32'd1);
    do_write(32'h0000_018C, 1'b0, 1'b1, 1'b1);
    do_lookup(32'h0000_020C);
    chk("rr1_victim_way", 32'(victim_way), 32'd1);
    chk("rr1_victim_tag", 32'(victim_tag), 32'd2);
    chk("rr1_victim_dirty", 32'(victim_dirty), 32'd0);
    do_write(32'h0000_020C, 1'b1, 1'b1, 1'b0);
    do_lookup(32'h0000_028C);
    chk("rr2_victim_way", 32'(victim_way), 32'd0);
    chk("rr2_victim_tag", 32'(victim_tag), 32'd3);
    chk("rr2_victim_dirty", 32'(victim_dirty), 32'd1);
    do_lookup(32'h0000_018C);
    chk("rr_hit_way0", 32'(hit), 32'd1);
    chk("rr_hit_way0_idx", 32'(hit_way), 32'd0);

    // Same-cycle lookup and write to set 7, tag 9: read-before-write
    lookup_valid = 1'b1; lookup_addr = 32'h0000_049C;
    wr_en = 1'b1; wr_addr = 32'h0000_049C; wr_way = 1'b0; wr_valid = 1'b1; wr_dirty = 1'b1;
    step();
    lookup_valid = 1'b0; wr_en = 1'b0;
    chk("rbw_resp", 32'(resp_valid), 32'd1);
    chk("rbw_hit", 32'(hit), 32'd0);
    do_lookup(32'h0000_049C);
    chk("rbw_rehit", 32'(hit), 32'd1);
    chk("rbw_rehit_way", 32'(hit_way), 32'd0);

    // Flush with a lookup in the same cycle; lookups and a write keep coming during the sweep
    flush = 1'b1; lookup_valid = 1'b1; lookup_addr = 32'h0000_049C;
    step();
    flush = 1'b0;
    wr_en = 1'b1; wr_addr = 32'h0000_0494; wr_way = 1'b0; wr_valid = 1'b1; wr_dirty = 1'b1;
    count_sweep(n, bad);
    chk("flush_sweep_len", n, 32);
    chk("flush_sweep_resp", bad, 0);
    chk("flush_exit_resp", 32'(resp_valid), 32'd0);
    lookup_valid = 1'b0; wr_en = 1'b0;
    do_lookup(32'h1234_5678);
    chk("fl_a_hit", 32'(hit), 32'd0);
    chk("fl_a_vdirty", 32'(victim_dirty), 32'd0);
    chk("fl_a_vvalid", 32'(victim_valid), 32'd0);
    do_lookup(32'h0000_018C);
    chk("fl_b_hit", 32'(hit), 32'd0);
    chk("fl_b_vdirty", 32'(victim_dirty), 32'd0);
    do_lookup(32'h0000_049C);
    chk("fl_c_hit", 32'(hit), 32'd0);
    chk("fl_c_vdirty", 32'(victim_dirty), 32'd0);
    do_lookup(32'h0000_0494);
    chk("fl_sweep_write_ignored", 32'(hit), 32'd0);

    // Reset at sweep cycle 10 restarts a full sweep
    flush = 1'b1;
    step();
    flush = 1'b0;
    bad = 0;
    for (int i = 0; i < 9; i++) begin
      if (ready) bad++;
      step();
    end
    chk("mid_ready_low", bad, 0);
    iRST = 1'b1;
    step();
    iRST = 1'b0;
    count_sweep(n, bad);
    chk("mid_rst_sweep_len", n, 32);
    chk("mid_rst_ready", 32'(ready), 32'd1);
    do_lookup(32'h0000_0040);
    chk("post_mid_resp", 32'(resp_valid), 32'd1);
    chk("post_mid_hit", 32'(hit), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_tag_array_nway.md
CACHE_TAG_ARRAY_NWAY -- requirements
Module: cache_tag_array_nway

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- ADDR_W, 32, byte address width.
- OFFSET_W, 2, block offset width.
- IDX_W, 5, set index width.
- WAYS, 2, associativity; legal values 1, 2, 4.
- Derived TAG_W = ADDR_W-IDX_W-OFFSET_W.
- Derived WAY_W = max(1, log2(WAYS)).
- Derived SETS = 2**IDX_W.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- iCLK, in, 1, clock.
- iRST, in, 1, reset, synchronous and active-high.
- lookup_valid, in, 1, lookup request.
- lookup_addr, in, ADDR_W, lookup address.
- wr_en, in, 1, tag-entry write request.
- wr_addr, in, ADDR_W, write address (supplies idx and tag).
- wr_way, in, WAY_W, way to write.
- wr_valid, in, 1, valid bit to store.
- wr_dirty, in, 1, dirty bit to store.
- flush, in, 1, start invalidate-all sweep.
- ready, out, 1, block accepts lookups and writes.
- resp_valid, out, 1, lookup response valid.
- hit, out, 1, lookup hit.
- hit_way, out, WAY_W, matching way.
- victim_way, out, WAY_W, replacement candidate.
- victim_valid, out, 1, victim entry valid.
- victim_dirty, out, 1, victim entry dirty (writeback needed).
- victim_tag, out, TAG_W, victim stored tag.

Function
REQ-003 Each entry SHALL be {valid, dirty, tag[TAG_W-1:0]}. Addresses SHALL split into idx = addr[OFFSET_W+IDX_W-1:OFFSET_W] and tag = addr[ADDR_W-1:OFFSET_W+IDX_W].
REQ-004 Each set SHALL hold a WAY_W-bit round-robin pointer rr_ptr.
REQ-005 The FSM SHALL have two states: SWEEP and IDLE. ready SHALL be 1 only in IDLE.
REQ-006 A lookup SHALL be accepted when ready && lookup_valid. Its outputs SHALL be registered and presented with resp_valid=1 exactly one cycle later. With ready && !lookup_valid, the next cycle SHALL have resp_valid=0.
REQ-007 hit SHALL be 1 iff some way of the set has valid=1 and a stored tag equal to the lookup tag. hit_way SHALL be the lowest-numbered matching way, or 0 on a miss.
REQ-008 victim_way SHALL be the lowest-numbered way with valid=0; if all ways are valid, it SHALL be rr_ptr of the set. victim_valid, victim_dirty and victim_tag SHALL be that way's stored fields.
REQ-009 A write SHALL be accepted when ready && wr_en. It SHALL store {wr_valid, wr_dirty, wr_addr tag} into way wr_way of set idx at the clock edge.
REQ-010 If an accepted write has wr_valid=1 and wr_way equals rr_ptr of the set, rr_ptr SHALL increment modulo WAYS (from WAYS-1 it wraps to 0). Otherwise rr_ptr SHALL be unchanged.
REQ-011 A lookup and a write in the same cycle to the same set SHALL respond with the pre-write contents (read-before-write). The write SHALL still complete.
REQ-012 When WAYS=1, hit_way and victim_way SHALL be constant 0 and rr_ptr SHALL be unused.
REQ-013 In IDLE, flush=1 SHALL move the FSM to SWEEP. A lookup or write presented in that same cycle SHALL be ignored.
REQ-014 SWEEP behaviour:
- A set counter starts at 0.
- Each cycle, valid=0, dirty=0 and rr_ptr=0 are written for all ways of set[counter], and the counter increments.
- After set SETS-1 is cleared, the FSM returns to IDLE; ready=1 the following cycle.
- Sweep length is exactly SETS cycles.
REQ-015 During SWEEP:
- lookup_valid, wr_en and flush SHALL be ignored.
- resp_valid SHALL be 0.
- Tag bits need not be cleared.

Reset
REQ-016 iRST=1 SHALL, at the clock edge, force the FSM to SWEEP with counter=0 and set resp_valid=0, hit=0, hit_way=0, victim_way=0, victim_valid=0, victim_dirty=0, victim_tag=0 and ready=0.
REQ-017 iRST asserted mid-sweep SHALL restart the sweep at set 0. iRST SHALL take priority over all other inputs.
REQ-018 No lookup SHALL report hit=1 for an entry written before the most recent reset or flush.

Verification
REQ-019 Bench SHALL cover, with defaults (WAYS=2, IDX_W=5, TAG_W=25):
- Reset: pulse iRST for 1 cycle -> ready=0 for 32 cycles, then ready=1; lookup of 0x0000_0040 -> resp_valid=1, hit=0, victim_way=0, victim_valid=0 one cycle later.
- Hit: write way 1, addr 0x1234_5678, valid=1, dirty=1; then lookup 0x1234_5678 -> hit=1, hit_way=1; lookup 0x1234_567C -> hit=0 (idx 0x1F vs 0x1E).
- Round-robin: fill ways 0 and 1 of idx 3, then lookup of a third tag in idx 3 -> victim_way=0, victim_valid=1. After rewriting way 0 -> victim_way=1. After rewriting way 1 -> victim_way=0 (wrap).
- Same-cycle: lookup and write to the same set and tag in one cycle -> response hit=0. A repeat lookup -> hit=1.
- Flush: dirty entries in several sets, assert flush -> ready=0 for exactly 32 cycles, resp_valid=0 throughout, lookups during the sweep produce no response. All later lookups -> hit=0, victim_dirty=0.
- Reset mid-sweep: assert iRST at sweep cycle 10 -> a full 32-cycle sweep follows before ready=1.
